// File: rtl/core_pkg.sv
// Shared core types for the vector-instruction completion path.
//   NrVFU        : number of completion sources (lane VFUs, VLU, VSU)
//   insn_id_t    : in-flight instruction identifier
//   vreg_t       : architectural vector register index
//   done_entry_t : one completion record handed to the committer
package core_pkg;

    localparam int unsigned NrVFU     = 4;
    localparam int unsigned NrInsnIds = 16;
    localparam int unsigned NrVRegs   = 32;

    typedef logic [$clog2(NrInsnIds)-1:0] insn_id_t;
    typedef logic [$clog2(NrVRegs)-1:0]   vreg_t;

    typedef struct packed {
        insn_id_t id;
        logic     illegal;
        logic     use_vd;
        vreg_t    vd;
    } done_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first valid index at or after ptr_i, wrapping modulo NrReq.
// The pointer itself is owned and updated by the parent.
//   valid_i     : per-requester valid
//   ptr_i       : search start index
//   gnt_o       : one-hot grant (zero when nothing is valid)
//   idx_o       : binary index of the granted requester
//   gnt_valid_o : some requester was picked
module rr_arbiter #(
    parameter  int unsigned NrReq = 4,
    localparam int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic [NrReq-1:0] valid_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [NrReq-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             gnt_valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o       = '0;
        idx_o       = '0;
        gnt_valid_o = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % NrReq);
            if (!gnt_valid_o && valid_i[cand]) begin
                gnt_valid_o = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vinsn_done_arbiter.sv
// Collects instruction completions from NrReq units plus illegal-instruction
// reports from the decoder and queues them in order for the committer.
// Illegal reports always win; otherwise one requester is granted round-robin.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   flush_i               : drop everything queued and refuse new pushes
//   req_valid_i/ready_o   : per-requester completion handshake
//   req_id_i/use_vd_i/vd_i: completion payload per requester
//   illegal_valid_i/id_i  : illegal-instruction report
//   illegal_ready_o       : illegal report accepted
//   done_valid_o/ready_i  : head-of-queue handshake towards the committer
//   done_*_o              : head entry fields
//   count_o               : queue occupancy
module vinsn_done_arbiter
    import core_pkg::*;
#(
    parameter int unsigned NrReq     = NrVFU,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [NrReq-1:0]               req_valid_i,
    output logic [NrReq-1:0]               req_ready_o,
    input  insn_id_t                       req_id_i     [NrReq],
    input  logic [NrReq-1:0]               req_use_vd_i,
    input  vreg_t                          req_vd_i     [NrReq],
    input  logic                           illegal_valid_i,
    input  insn_id_t                       illegal_id_i,
    output logic                           illegal_ready_o,
    output logic                           done_valid_o,
    input  logic                           done_ready_i,
    output insn_id_t                       done_id_o,
    output logic                           done_illegal_o,
    output logic                           done_use_vd_o,
    output vreg_t                          done_vd_o,
    output logic [$clog2(FifoDepth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

    done_entry_t     mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NrReq-1:0] arb_gnt;
    logic [IdxW-1:0]  arb_idx;
    logic             arb_gnt_valid;

    logic        pop_raw, pop, can_push, accept_en, arb_en, grant, push;
    done_entry_t push_entry, head;

    rr_arbiter #(.NrReq(NrReq)) i_rr_arbiter (
        .valid_i     (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (arb_gnt),
        .idx_o       (arb_idx),
        .gnt_valid_o (arb_gnt_valid)
    );

    assign done_valid_o = (count_q != '0);
    assign pop_raw      = done_valid_o && done_ready_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign can_push     = (count_q < CntW'(FifoDepth)) || pop_raw;
    assign accept_en    = can_push && !flush_i;

    assign illegal_ready_o = illegal_valid_i && accept_en;
    // Requesters are locked out whenever an illegal report is pending.
    assign arb_en      = accept_en && !illegal_valid_i;
    assign req_ready_o = arb_en ? arb_gnt : '0;
    assign grant       = arb_en && arb_gnt_valid;

    assign push = illegal_ready_o || grant;
    assign pop  = pop_raw && !flush_i;

    always_comb begin
        push_entry = '0;
        if (illegal_valid_i) begin
            push_entry.id      = illegal_id_i;
            push_entry.illegal = 1'b1;
        end else begin
            push_entry.id     = req_id_i[arb_idx];
            push_entry.use_vd = req_use_vd_i[arb_idx];
            push_entry.vd     = req_vd_i[arb_idx];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CntW'(push) - CntW'(pop);
            if (grant) begin
                rr_ptr_d = (arb_idx == IdxW'(NrReq - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head           = mem_q[rd_ptr_q];
    assign done_id_o      = head.id;
    assign done_illegal_o = head.illegal;
    assign done_use_vd_o  = head.use_vd;
    assign done_vd_o      = head.vd;
    assign count_o        = count_q;

endmodule

// File: tb/tb_vinsn_done_arbiter.sv
module tb_vinsn_done_arbiter;
    import core_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst, flush;
    logic [N-1:0]   req_valid, req_ready, req_use_vd;
    insn_id_t       req_id [N];
    vreg_t          req_vd [N];
    logic           illegal_valid, illegal_ready;
    insn_id_t       illegal_id;
    logic           done_valid, done_ready, done_illegal, done_use_vd;
    insn_id_t       done_id;
    vreg_t          done_vd;
    logic [2:0]     count;

    int checks   = 0;
    int failures = 0;

    // Reference model: ordered list of queued completions plus search start.
    done_entry_t mq[$];
    int          rr;
    logic        exp_ill;
    logic [N-1:0] exp_req;
    int          exp_k;
    logic        exp_pop;

    always #5 clk = ~clk;

    vinsn_done_arbiter #(.NrReq(N), .FifoDepth(DEPTH)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_id_i        (req_id),
        .req_use_vd_i    (req_use_vd),
        .req_vd_i        (req_vd),
        .illegal_valid_i (illegal_valid),
        .illegal_id_i    (illegal_id),
        .illegal_ready_o (illegal_ready),
        .done_valid_o    (done_valid),
        .done_ready_i    (done_ready),
        .done_id_o       (done_id),
        .done_illegal_o  (done_illegal),
        .done_use_vd_o   (done_use_vd),
        .done_vd_o       (done_vd),
        .count_o         (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic settle_check();
        int  cnt;
        logic can_push, acc;
        done_entry_t head;
        #2;
        cnt      = mq.size();
        exp_pop  = (cnt > 0) && done_ready;
        can_push = (cnt < DEPTH) || exp_pop;
        acc      = can_push && !flush;
        exp_ill  = illegal_valid && acc;
        exp_req  = '0;
        exp_k    = -1;
        if (acc && !illegal_valid) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (rr + i) % N;
                if (exp_k < 0 && req_valid[k]) exp_k = k;
            end
            if (exp_k >= 0) exp_req[exp_k] = 1'b1;
        end
        chk("done_valid", 32'(done_valid), 32'(cnt > 0));
        chk("count", 32'(count), 32'(cnt));
        chk("illegal_ready", 32'(illegal_ready), 32'(exp_ill));
        chk("req_ready", 32'(req_ready), 32'(exp_req));
        if (cnt > 0) begin
            head = '{id: done_id, illegal: done_illegal, use_vd: done_use_vd, vd: done_vd};
            chk("head_entry", 32'(head), 32'(mq[0]));
        end
    endtask

    task automatic clock_update();
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            rr = 0;
        end else begin
            if (exp_pop) void'(mq.pop_front());
            if (exp_ill) begin
                mq.push_back('{id: illegal_id, illegal: 1'b1, use_vd: 1'b0, vd: '0});
            end else if (exp_k >= 0) begin
                mq.push_back('{id: req_id[exp_k], illegal: 1'b0,
                               use_vd: req_use_vd[exp_k], vd: req_vd[exp_k]});
                rr = (exp_k + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle_check();
        clock_update();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_use_vd = '0;
        illegal_valid = 1'b0; illegal_id = '0; done_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_id[i] = insn_id_t'(i + 1);
            req_vd[i] = vreg_t'(8 + i);
        end
        mq.delete();
        rr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        step();
        chk("reset_count", 32'(count), 32'd0);

        // Round-robin rotation with all requesters valid
        req_valid = 4'b1111; req_use_vd = 4'b0101; done_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle_check();
            chk("rr_rotation", 32'(req_ready), 32'(1 << (i % 4)));
            clock_update();
        end
        req_valid = '0;
        repeat (2) step();

        // Illegal report beats a concurrent requester
        illegal_valid = 1'b1; illegal_id = insn_id_t'(5); req_valid = 4'b0100;
        settle_check();
        chk("illegal_prio_ill", 32'(illegal_ready), 32'd1);
        chk("illegal_prio_req", 32'(req_ready), 32'd0);
        clock_update();
        illegal_valid = 1'b0;
        settle_check();
        chk("illegal_head_id", 32'(done_id), 32'd5);
        chk("illegal_head_flag", 32'(done_illegal), 32'd1);
        chk("after_illegal_grant", 32'(req_ready), 32'b0100);
        clock_update();
        req_valid = '0;
        repeat (2) step();

        // Fill to capacity, fifth request waits for a pop
        done_ready = 1'b0; req_valid = 4'b1111;
        repeat (4) step();
        settle_check();
        chk("full_count", 32'(count), 32'd4);
        chk("full_blocked", 32'(req_ready), 32'd0);
        clock_update();
        done_ready = 1'b1;
        settle_check();
        chk("full_push_pop", 32'(req_ready != '0), 32'd1);
        clock_update();
        settle_check();
        chk("full_count_kept", 32'(count), 32'd4);
        clock_update();
        req_valid = '0;
        repeat (6) step();

        // Flush with three entries queued
        done_ready = 1'b0; req_valid = 4'b0110;
        repeat (3) step();
        flush = 1'b1; req_valid = 4'b0001;
        settle_check();
        chk("flush_ready", 32'(req_ready), 32'd0);
        clock_update();
        flush = 1'b0; req_valid = 4'b1111;
        settle_check();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(done_valid), 32'd0);
        chk("flush_rr_start", 32'(req_ready), 32'b0001);
        clock_update();
        step();

        // Reset with two entries queued
        chk("pre_reset_count", 32'(count), 32'd2);
        rst = 1'b1; req_valid = '0;
        step();
        rst = 1'b0; done_ready = 1'b1;
        settle_check();
        chk("reset_drop_count", 32'(count), 32'd0);
        chk("reset_drop_valid", 32'(done_valid), 32'd0);
        clock_update();
        repeat (3) step();

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            rst           = ($urandom_range(0, 59) == 0);
            flush         = ($urandom_range(0, 24) == 0);
            illegal_valid = ($urandom_range(0, 5) == 0);
            illegal_id    = insn_id_t'($urandom);
            req_valid     = N'($urandom);
            req_use_vd    = N'($urandom);
            done_ready    = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_id[i] = insn_id_t'($urandom);
                req_vd[i] = vreg_t'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
